// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the digit-by-digit square root and normalise blocks.
// The iteration step works on a wide fixed width so callers of any size can reuse it.
package sqrt_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FINISH,
      S_HOLD
   } sqrt_state_e;

   localparam int unsigned SQRT_MAX_W = 64;

   typedef struct packed {
      logic [SQRT_MAX_W-1:0] rem;
      logic [SQRT_MAX_W-1:0] root;
   } sqrt_step_t;

   function automatic int unsigned sqrt_q_int_b(input int unsigned a_int_b);
      return (a_int_b + 1) / 2;
   endfunction

   // One restoring step: bring in two radicand bits, try (root<<2)|1, keep on success.
   function automatic sqrt_step_t sqrt_step(input logic [SQRT_MAX_W-1:0] rem,
                                            input logic [SQRT_MAX_W-1:0] root,
                                            input logic [1:0]            bits);
      sqrt_step_t            res;
      logic [SQRT_MAX_W-1:0] trial;
      res.rem  = {rem[SQRT_MAX_W-3:0], bits};
      trial    = {root[SQRT_MAX_W-3:0], 2'b01};
      res.root = {root[SQRT_MAX_W-2:0], 1'b0};
      if (res.rem >= trial) begin
         res.rem     = res.rem - trial;
         res.root[0] = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sqrt_fixed_iter.sv
// Handshaked fixed-point square root, one root bit per cycle, optional round-to-nearest.
// Carries a user tag alongside each result and flags roots that are exact.
module sqrt_fixed_iter
   import sqrt_pkg::*;
#(
   parameter int unsigned A_INT_B = 8,
   parameter int unsigned A_FP_B  = 4,
   parameter int unsigned Q_FP_B  = 16,
   parameter int unsigned ROUND   = 0,
   parameter int unsigned TAG_W   = 4,
   localparam int unsigned Q_INT_B = sqrt_q_int_b(A_INT_B),
   localparam int unsigned Q_W     = Q_INT_B + Q_FP_B,
   localparam int unsigned N_IT    = Q_W + ROUND
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [A_INT_B+A_FP_B-1:0]  in_a,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [Q_W-1:0]             out_q,
   output logic                       out_exact,
   output logic [TAG_W-1:0]           out_tag
);

   localparam int unsigned RAD_W = 2 * N_IT;
   localparam int unsigned REM_W = N_IT + 2;
   localparam int unsigned SHIFT = 2 * Q_FP_B - A_FP_B + 2 * ROUND;
   localparam int unsigned CNT_W = $clog2(N_IT + 1);
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(N_IT - 1);

   if (2 * Q_FP_B < A_FP_B) begin : g_bad_cfg
      $error("sqrt_fixed_iter: Q_FP_B must satisfy 2*Q_FP_B >= A_FP_B");
   end

   sqrt_state_e state, state_nxt;

   logic                  accept;
   logic                  a_zero;
   logic [RAD_W-1:0]      rad;
   logic [REM_W-1:0]      rem;
   logic [N_IT-1:0]       root;
   logic [CNT_W-1:0]      cnt;
   sqrt_step_t            step;
   logic [SQRT_MAX_W-REM_W-1:0] rem_hi_unused;
   logic [SQRT_MAX_W-N_IT-1:0]  root_hi_unused;
   logic [REM_W-1:0]      rem_step;
   logic [N_IT-1:0]       root_step;
   logic [Q_W-1:0]        q_final;
   logic                  exact_final;

   assign a_zero = (in_a == '0);
   assign accept = in_valid && in_ready;

   always_comb begin
      step = sqrt_step(SQRT_MAX_W'(rem), SQRT_MAX_W'(root), rad[RAD_W-1 -: 2]);
   end

   assign {rem_hi_unused, rem_step}   = step.rem;
   assign {root_hi_unused, root_step} = step.root;

   // The extra guard bit decides rounding; a carry out of the top saturates.
   if (ROUND != 0) begin : g_round
      logic [Q_W:0] sum;
      assign sum         = {1'b0, root[N_IT-1:1]} + {{Q_W{1'b0}}, root[0]};
      assign q_final     = sum[Q_W] ? '1 : sum[Q_W-1:0];
      assign exact_final = (rem == '0) && !root[0];
   end else begin : g_trunc
      assign q_final     = root;
      assign exact_final = (rem == '0);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A zero radicand skips CALC but still passes through FINISH, giving one cycle of latency.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = a_zero ? S_FINISH : S_CALC;
         end
         S_CALC: begin
            if (cnt == LAST_IT) state_nxt = S_FINISH;
         end
         S_FINISH: begin
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (!in_valid) state_nxt = S_IDLE;
               else           state_nxt = a_zero ? S_FINISH : S_CALC;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         rad       <= '0;
         rem       <= '0;
         root      <= '0;
         cnt       <= '0;
         out_q     <= '0;
         out_exact <= 1'b0;
         out_tag   <= '0;
      end else begin
         if (accept) begin
            rad     <= RAD_W'(in_a) << SHIFT;
            rem     <= '0;
            root    <= '0;
            cnt     <= '0;
            out_tag <= in_tag;
         end else if (state == S_CALC) begin
            rad  <= rad << 2;
            rem  <= rem_step;
            root <= root_step;
            cnt  <= cnt + 1'b1;
         end
         if (state == S_FINISH) begin
            out_q     <= q_final;
            out_exact <= exact_final;
         end
      end
   end

endmodule

// File: tb/tb_sqrt_fixed_iter.sv
// Bench for sqrt_fixed_iter: a truncating and a rounding instance driven one at a time,
// checked against an integer-search square root reference.
module tb_sqrt_fixed_iter;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic [1:0]  in_valid = '0;
   logic [11:0] in_a = '0;
   logic [3:0]  in_tag = '0;
   logic        out_ready = 1'b0;
   logic [1:0]  in_ready;
   logic [1:0]  out_valid;
   logic [1:0]  out_exact;
   logic [19:0] out_q [2];
   logic [3:0]  out_tag [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sqrt_fixed_iter #(.A_INT_B(8), .A_FP_B(4), .Q_FP_B(16), .ROUND(0), .TAG_W(4)) u_trunc (
      .clk(clk), .rst_(rst_), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a), .in_tag(in_tag), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_q(out_q[0]), .out_exact(out_exact[0]), .out_tag(out_tag[0]));

   sqrt_fixed_iter #(.A_INT_B(8), .A_FP_B(4), .Q_FP_B(16), .ROUND(1), .TAG_W(4)) u_round (
      .clk(clk), .rst_(rst_), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a), .in_tag(in_tag), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_q(out_q[1]), .out_exact(out_exact[1]), .out_tag(out_tag[1]));

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Largest r with r*r <= A*2^(28+2*rnd), found by bisection; rounding from the guard bit.
   function automatic logic [20:0] ref_sqrt(input int unsigned a, input int unsigned rnd);
      longint unsigned t, lo, hi, mid, q;
      t  = longint'(a) << (28 + 2 * rnd);
      lo = 0;
      hi = 64'd1 << 22;
      while (hi - lo > 1) begin
         mid = (lo + hi) >> 1;
         if (mid * mid <= t) lo = mid;
         else                hi = mid;
      end
      q = (rnd != 0) ? (lo >> 1) + (lo & 1) : lo;
      if (q > 64'hFFFFF) q = 64'hFFFFF;
      return {(q * q == (longint'(a) << 28)), q[19:0]};
   endfunction

   task automatic start(input int sel, input logic [11:0] a, input logic [3:0] tag);
      int guard = 0;
      in_a = a;
      in_tag = tag;
      in_valid[sel] = 1'b1;
      #1;
      while (!in_ready[sel] && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("accept_wait", {63'd0, (guard < 200)}, 64'd1);
      @(posedge clk); #1;
      in_valid[sel] = 1'b0;
   endtask

   task automatic wait_result(input int sel, output int lat);
      lat = 0;
      while (!out_valid[sel] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_check(input int sel, input logic [11:0] a, input logic [3:0] tag,
                            input logic [19:0] exp_q, input logic exp_x, input string name);
      int lat;
      start(sel, a, tag);
      wait_result(sel, lat);
      check({name, "/q"},       out_q[sel],     exp_q);
      check({name, "/exact"},   out_exact[sel], exp_x);
      check({name, "/tag"},     out_tag[sel],   tag);
      check({name, "/latency"}, lat,            (a == 0) ? 1 : 21 + sel);
      release_result();
   endtask

   logic [11:0] d_a  [5] = '{12'h040, 12'h020, 12'hFFF, 12'h001, 12'h000};
   logic [19:0] d_q0 [5] = '{20'h20000, 20'h16A09, 20'hFFF7F, 20'h04000, 20'h00000};
   logic [19:0] d_q1 [5] = '{20'h20000, 20'h16A0A, 20'hFFF80, 20'h04000, 20'h00000};
   logic        d_x  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int          lat;
      logic [11:0] a;
      logic [20:0] r;

      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check("reset/out_valid", out_valid[s], 1'b0);
         check("reset/out_q",     out_q[s],     20'h0);
         check("reset/out_exact", out_exact[s], 1'b0);
         check("reset/out_tag",   out_tag[s],   4'h0);
         check("reset/in_ready",  in_ready[s],  1'b1);
      end
      rst_ = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         run_check(0, d_a[i], 4'(i + 1), d_q0[i], d_x[i], "directed_trunc");
         run_check(1, d_a[i], 4'(i + 6), d_q1[i], d_x[i], "directed_round");
      end

      // Backpressure, then same-cycle handoff from HOLD with a new tag.
      start(0, 12'h040, 4'h5);
      wait_result(0, lat);
      check("bp/latency", lat, 21);
      for (int c = 0; c < 5; c++) begin
         check("bp/out_valid", out_valid[0], 1'b1);
         check("bp/out_q",     out_q[0],     20'h20000);
         check("bp/out_exact", out_exact[0], 1'b1);
         check("bp/out_tag",   out_tag[0],   4'h5);
         check("bp/in_ready",  in_ready[0],  1'b0);
         @(posedge clk); #1;
      end
      in_a = 12'h090;
      in_tag = 4'hA;
      in_valid[0] = 1'b1;
      out_ready = 1'b1;
      #1;
      check("handoff/in_ready", in_ready[0], 1'b1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      out_ready = 1'b0;
      check("handoff/out_valid_drop", out_valid[0], 1'b0);
      wait_result(0, lat);
      check("handoff/latency", lat, 21);
      check("handoff/out_q",   out_q[0],     20'h30000);
      check("handoff/exact",   out_exact[0], 1'b1);
      check("handoff/out_tag", out_tag[0],   4'hA);
      release_result();

      // Asynchronous reset in the middle of iteration 7.
      start(0, 12'h020, 4'h3);
      repeat (7) @(posedge clk);
      #3;
      rst_ = 1'b0;
      #1;
      check("midreset/out_valid", out_valid[0], 1'b0);
      check("midreset/out_q",     out_q[0],     20'h0);
      check("midreset/out_exact", out_exact[0], 1'b0);
      check("midreset/out_tag",   out_tag[0],   4'h0);
      check("midreset/in_ready",  in_ready[0],  1'b1);
      #2;
      rst_ = 1'b1;
      @(posedge clk); #1;
      run_check(0, 12'h090, 4'h9, 20'h30000, 1'b1, "after_reset");

      for (int i = 0; i < 600; i++) begin
         a = 12'($urandom_range(0, 4095));
         for (int s = 0; s < 2; s++) begin
            r = ref_sqrt(a, s);
            run_check(s, a, 4'(i), r[19:0], r[20], (s == 0) ? "random_trunc" : "random_round");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
